// File: rtl/mic_pair_arbiter.sv
// mic_pair_arbiter
//   Round-robin arbiter that funnels stereo samples from N mic-pair receivers
//   into one shared codec write port. A two-state FSM (IDLE/SEND) grants one
//   requester in IDLE, registers its sample, and holds it in SEND until the
//   codec accepts it. Per-requester wait counters raise sticky stall flags
//   for requesters that wait too long, including disabled-but-valid ones.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. On the request side req_ready is a one-hot, combinational accept
//   that is only ever raised in IDLE for the round-robin winner. On the codec
//   side out_valid, out_left, out_right and out_src stay stable while
//   out_valid=1 and out_ready=0.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   req_valid  : [N]   requester i has a stereo sample pending
//   req_left   : [N*W] left sample of requester i at [i*W +: W]
//   req_right  : [N*W] right sample of requester i at [i*W +: W]
//   req_ready  : [N]   one-hot accept of requester i
//   enable     : [N]   requester i may be granted only while enable[i]=1
//   out_valid  : sample presented to the codec
//   out_ready  : codec accepts the presented sample
//   out_left   : [W] left sample presented
//   out_right  : [W] right sample presented
//   out_src    : [2] index of the requester whose sample is presented
//   stall      : [N] sticky per-requester starvation flags
//   clr_stall  : clears all stall flags (a new stall event wins)
module mic_pair_arbiter #(
   parameter int N       = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_left,
   input  logic [N*W-1:0] req_right,
   output logic [N-1:0]   req_ready,
   input  logic [N-1:0]   enable,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_left,
   output logic [W-1:0]   out_right,
   output logic [1:0]     out_src,
   output logic [N-1:0]   stall,
   input  logic           clr_stall
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t         state_q, state_d;
   logic [1:0]     rr_ptr_q, rr_ptr_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_left_q, out_left_d;
   logic [W-1:0]   out_right_q, out_right_d;
   logic [1:0]     out_src_q, out_src_d;
   logic [N-1:0]   stall_q, stall_d;
   logic [7:0]     wait_q [N];
   logic [7:0]     wait_d [N];

   logic [N-1:0]   elig;
   logic [N-1:0]   grant;
   logic [1:0]     win_idx;
   logic           win_found;

   // Winner search starts at rr_ptr and wraps; the 2-bit index add wraps
   // naturally because N is fixed at 4.
   always_comb begin
      elig      = req_valid & enable;
      grant     = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!win_found && elig[rr_ptr_q + 2'(k)]) begin
            win_found = 1'b1;
            win_idx   = rr_ptr_q + 2'(k);
         end
      end
      if (reset_n && (state_q == IDLE) && win_found) begin
         grant[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_left_d  = out_left_q;
      out_right_d = out_right_q;
      out_src_d   = out_src_q;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               out_valid_d = 1'b1;
               out_left_d  = req_left[int'(win_idx)*W +: W];
               out_right_d = req_right[int'(win_idx)*W +: W];
               out_src_d   = win_idx;
               state_d     = SEND;
            end
         end
         SEND: begin
            // enable is deliberately ignored here so a granted transfer always completes.
            if (out_ready) begin
               out_valid_d = 1'b0;
               rr_ptr_d    = out_src_q + 2'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall flag: the edge where the counter first reaches TIMEOUT sets it even
   // against clr_stall. A requester still starving after a clear re-flags on
   // the following cycle, so the clear shows as a one-cycle dip.
   always_comb begin
      stall_d = '0;
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] || grant[i]) begin
            wait_d[i] = 8'd0;
         end else if (wait_q[i] != 8'hFF) begin
            wait_d[i] = wait_q[i] + 8'd1;
         end else begin
            wait_d[i] = wait_q[i];
         end
         stall_d[i] = ((wait_d[i] == TO) && (wait_q[i] != TO)) ||
                      ((stall_q[i] || (req_valid[i] && !grant[i] && (wait_q[i] >= TO)))
                       && !clr_stall);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_left_q  <= '0;
         out_right_q <= '0;
         out_src_q   <= '0;
         stall_q     <= '0;
         for (int i = 0; i < N; i++) wait_q[i] <= 8'd0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_left_q  <= out_left_d;
         out_right_q <= out_right_d;
         out_src_q   <= out_src_d;
         stall_q     <= stall_d;
         for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign req_ready = grant;
   assign out_valid = out_valid_q;
   assign out_left  = out_left_q;
   assign out_right = out_right_q;
   assign out_src   = out_src_q;
   assign stall     = stall_q;

endmodule

// File: tb/tb_mic_pair_arbiter.sv
// Directed bench for mic_pair_arbiter: reset, single request, round-robin,
// backpressure, enable mask with stall/clear, and reset during SEND.
module tb_mic_pair_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_left;
   logic [N*W-1:0] req_right;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   enable;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_left;
   logic [W-1:0]   out_right;
   logic [1:0]     out_src;
   logic [N-1:0]   stall;
   logic           clr_stall;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   mic_pair_arbiter #(.N(N), .W(W), .TIMEOUT(255)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_left  (req_left),
      .req_right (req_right),
      .req_ready (req_ready),
      .enable    (enable),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_left  (out_left),
      .out_right (out_right),
      .out_src   (out_src),
      .stall     (stall),
      .clr_stall (clr_stall)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
      req_left[i*W +: W]  = l;
      req_right[i*W +: W] = r;
   endtask

   task automatic load_default_data();
      for (int i = 0; i < N; i++) set_data(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
   endtask

   // One full grant with out_ready=1: IDLE accept, SEND present, back to IDLE.
   task automatic do_grant(input int src);
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      exp_ready[src] = 1'b1;
      settle();
      check("rr_ready", {60'd0, req_ready}, {60'd0, exp_ready});
      tick();
      check("rr_valid", {63'd0, out_valid}, 64'd1);
      check("rr_src", {62'd0, out_src}, 64'(src));
      check("rr_left", {48'd0, out_left}, 64'(16'h1000 + 16'(src)));
      check("rr_right", {48'd0, out_right}, 64'(16'h2000 + 16'(src)));
      check("rr_send_ready", {60'd0, req_ready}, 64'd0);
      tick();
      check("rr_idle_valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '1;
      enable    = '1;
      req_left  = '0;
      req_right = '0;
      out_ready = 1'b0;
      clr_stall = 1'b0;

      // Reset: req_ready held low while reset_n=0, registers cleared.
      settle();
      check("rst_ready_pre", {60'd0, req_ready}, 64'd0);
      tick();
      tick();
      check("rst_ready", {60'd0, req_ready}, 64'd0);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_left", {48'd0, out_left}, 64'd0);
      check("rst_right", {48'd0, out_right}, 64'd0);
      check("rst_src", {62'd0, out_src}, 64'd0);
      check("rst_stall", {60'd0, stall}, 64'd0);
      req_valid = '0;
      reset_n   = 1'b1;
      tick();

      // Single request.
      set_data(0, 16'h1234, 16'hABCD);
      req_valid = 4'b0001;
      settle();
      check("single_ready", {60'd0, req_ready}, 64'b0001);
      tick();
      req_valid = 4'b0000;
      settle();
      check("single_valid", {63'd0, out_valid}, 64'd1);
      check("single_src", {62'd0, out_src}, 64'd0);
      check("single_left", {48'd0, out_left}, 64'h1234);
      check("single_right", {48'd0, out_right}, 64'hABCD);
      check("single_send_ready", {60'd0, req_ready}, 64'd0);
      out_ready = 1'b1;
      tick();
      check("single_done", {63'd0, out_valid}, 64'd0);

      // Round-robin: pointer is now 1, so grants go 1,2,3,0,1.
      load_default_data();
      req_valid = 4'b1111;
      do_grant(1);
      do_grant(2);
      do_grant(3);
      do_grant(0);
      do_grant(1);

      // Backpressure: winner 2 held for 10 cycles while inputs change around it.
      out_ready = 1'b0;
      settle();
      check("bp_ready", {60'd0, req_ready}, 64'b0100);
      tick();
      enable = 4'b1011;
      set_data(2, 16'hDEAD, 16'hBEEF);
      for (int c = 0; c < 10; c++) begin
         settle();
         check("bp_valid", {63'd0, out_valid}, 64'd1);
         check("bp_src", {62'd0, out_src}, 64'd2);
         check("bp_left", {48'd0, out_left}, 64'h1002);
         check("bp_right", {48'd0, out_right}, 64'h2002);
         check("bp_req_ready", {60'd0, req_ready}, 64'd0);
         tick();
      end
      out_ready = 1'b1;
      settle();
      check("bp_final_valid", {63'd0, out_valid}, 64'd1);
      tick();
      check("bp_release", {63'd0, out_valid}, 64'd0);
      check("bp_next_ready", {60'd0, req_ready}, 64'b1000);
      req_valid = 4'b0000;
      enable    = 4'b1111;
      load_default_data();
      tick();

      // Enable mask: only 1 and 3 granted; 0 and 2 starve and flag stall.
      enable    = 4'b1010;
      req_valid = 4'b1111;
      for (int g = 0; g < 127; g++) do_grant((g % 2 == 0) ? 3 : 1);
      check("mask_stall_early", {60'd0, stall}, 64'd0);
      tick();
      check("mask_stall_set", {60'd0, stall}, 64'b0101);
      clr_stall = 1'b1;
      tick();
      check("mask_stall_clr", {60'd0, stall}, 64'd0);
      clr_stall = 1'b0;
      tick();
      check("mask_stall_reset", {60'd0, stall}, 64'b0101);

      // Set beats clear: counters restarted, clr_stall held high throughout.
      req_valid = 4'b0000;
      clr_stall = 1'b1;
      tick();
      check("win_cleared", {60'd0, stall}, 64'd0);
      req_valid = 4'b0101;
      for (int c = 0; c < 254; c++) tick();
      check("win_stall_early", {60'd0, stall}, 64'd0);
      tick();
      check("win_stall_set", {60'd0, stall}, 64'b0101);
      clr_stall = 1'b0;
      req_valid = 4'b0000;
      enable    = 4'b1111;
      tick();
      check("win_sticky", {60'd0, stall}, 64'b0101);

      // Reset during SEND.
      out_ready = 1'b0;
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0000;
      settle();
      check("mid_valid", {63'd0, out_valid}, 64'd1);
      check("mid_src", {62'd0, out_src}, 64'd3);
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      settle();
      check("mid_rst_ready", {60'd0, req_ready}, 64'd0);
      tick();
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_stall", {60'd0, stall}, 64'd0);
      reset_n = 1'b1;
      settle();
      check("mid_first_ready", {60'd0, req_ready}, 64'b0001);
      tick();
      check("mid_first_src", {62'd0, out_src}, 64'd0);
      check("mid_first_valid", {63'd0, out_valid}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mic_pair_arbiter.md
MIC_PAIR_ARBITER -- requirements
Module: mic_pair_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, the number of requesters (mic-pair receivers); it is fixed at 4 for this release.
REQ-002 The block SHALL have parameter W, default 16, the sample width per channel.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the wait-cycle limit before a stall is flagged.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port req_valid, input, N bits: requester i has a stereo sample pending.
REQ-007 Port req_left, input, N*W bits: left sample of requester i at bits [i*W +: W].
REQ-008 Port req_right, input, N*W bits: right sample of requester i at bits [i*W +: W].
REQ-009 Port req_ready, output, N bits: one-hot accept of requester i.
REQ-010 Port enable, input, N bits: requester i may be granted only while enable[i]=1.
REQ-011 Port out_valid, output, 1 bit: a sample is presented to the shared codec write port.
REQ-012 Port out_ready, input, 1 bit: the codec write port accepts the sample.
REQ-013 Port out_left, output, W bits: left sample presented.
REQ-014 Port out_right, output, W bits: right sample presented.
REQ-015 Port out_src, output, 2 bits: index of the requester whose sample is presented.
REQ-016 Port stall, output, N bits: sticky per-requester starvation flags.
REQ-017 Port clr_stall, input, 1 bit: clears all stall flags.

Function
REQ-018 The FSM SHALL have two states: IDLE and SEND.
REQ-019 Eligible set: elig = req_valid & enable.
REQ-020 In IDLE, the winner SHALL be the first set bit of elig, searching upward from rr_ptr and wrapping from N-1 to 0.
REQ-021 In IDLE with elig != 0, req_ready SHALL assert combinationally for the winner only; elsewhere req_ready SHALL be 0.
REQ-022 On that IDLE cycle's clock edge, the block SHALL latch the winner's left/right data into out_left/out_right and the winner index into out_src, set out_valid=1, and move to SEND; latency from accept to out_valid is 1 cycle.
REQ-023 In SEND, out_valid, out_left, out_right and out_src SHALL be held stable until out_ready=1.
REQ-024 In SEND with out_ready=1, the block SHALL clear out_valid, set rr_ptr=(out_src+1) mod N, and return to IDLE.
REQ-025 Maximum throughput SHALL be one sample per 2 cycles.
REQ-026 In SEND, req_ready SHALL be 0 for all requesters, whatever the inputs.
REQ-027 Clearing enable[i] during SEND for i=out_src SHALL NOT abort the transfer.
REQ-028 Each requester SHALL have an 8-bit wait counter.
REQ-029 Wait counter i SHALL increment, saturating at 255, on every cycle with req_valid[i]=1 and no accept of requester i.
REQ-030 Wait counter i SHALL clear to 0 on accept of requester i or when req_valid[i]=0.
REQ-031 stall[i] SHALL set the cycle wait counter i reaches TIMEOUT and stay set until clr_stall=1.
REQ-032 If clr_stall=1 and a set condition occur in the same cycle, set SHALL win.
REQ-033 Disabled requesters with req_valid=1 SHALL still count; a disabled-but-valid requester SHALL eventually flag stall.
REQ-034 The block SHALL perform no arithmetic on sample data; data passes bit-exact.

Reset
REQ-035 With reset_n=0 at a clock edge: state=IDLE, rr_ptr=0, out_valid=0, out_left=0, out_right=0, out_src=0, stall=0, all wait counters=0.
REQ-036 req_ready SHALL be 0 during any cycle with reset_n=0.
REQ-037 Reset asserted during SEND SHALL drop out_valid on the next edge; the pending sample is discarded.

Verification
REQ-038 Single request: req_valid=0001, left=16'h1234, right=16'hABCD -> req_ready=0001 for 1 cycle; next cycle out_valid=1, out_src=0, data 1234/ABCD; after out_ready, rr_ptr=1.
REQ-039 Round-robin: all four valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0, one grant every 2 cycles.
REQ-040 Backpressure: out_ready=0 for 10 cycles in SEND -> outputs stable, req_ready=0000; on the 11th cycle out_ready=1, then IDLE.
REQ-041 Enable mask: enable=1010, all valid -> grants alternate 1,3 only; stall[0] and stall[2] set after 255 cycles; clr_stall=1 clears them for 1 cycle, after which they re-set.
REQ-042 Reset mid-SEND: reset_n=0 for 1 cycle while out_valid=1 -> out_valid=0, stall=0000, first grant after release goes to requester 0.
